// File: rtl/ec_decrypt_seq.sv
// ElGamal EC decryption scheduler: M = C2 - k*C1 by MSB-first double-and-add, then a final
// subtraction, with all point arithmetic delegated to a shared req/ack point unit.
module ec_decrypt_seq #(
   parameter int          WIDTH = 16,
   parameter int unsigned PRIME = 16'd65521
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] secret_key,
   input  logic [WIDTH-1:0] c1x,
   input  logic [WIDTH-1:0] c1y,
   input  logic [WIDTH-1:0] c2x,
   input  logic [WIDTH-1:0] c2y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] mx,
   output logic [WIDTH-1:0] my,
   output logic             m_inf,
   output logic             op_req,
   output logic             op_dbl,
   output logic [WIDTH-1:0] op_ax,
   output logic [WIDTH-1:0] op_ay,
   output logic             op_a_inf,
   output logic [WIDTH-1:0] op_bx,
   output logic [WIDTH-1:0] op_by,
   output logic             op_b_inf,
   input  logic             op_ack,
   input  logic [WIDTH-1:0] op_rx,
   input  logic [WIDTH-1:0] op_ry,
   input  logic             op_r_inf
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] PRIME_W = PRIME[WIDTH-1:0];

   typedef enum logic [3:0] {
      S_IDLE, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_SUB, S_SUB_WAIT, S_DONE
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] k_reg, c1x_reg, c1y_reg, c2x_reg, c2y_reg;
   logic [WIDTH-1:0] rx_reg, ry_reg;
   logic             r_inf_reg;
   logic [IW-1:0]    idx_reg;
   logic [WIDTH-1:0] neg_y;
   logic             op_done;

   // -R keeps y=0 points fixed so PRIME-0 never leaks out as an unreduced value
   assign neg_y   = (ry_reg == '0) ? '0 : PRIME_W - ry_reg;
   assign op_done = op_req && op_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         k_reg     <= '0;
         c1x_reg   <= '0;
         c1y_reg   <= '0;
         c2x_reg   <= '0;
         c2y_reg   <= '0;
         rx_reg    <= '0;
         ry_reg    <= '0;
         r_inf_reg <= 1'b1;
         idx_reg   <= IW'(WIDTH - 1);
         busy      <= 1'b0;
         done      <= 1'b0;
         mx        <= '0;
         my        <= '0;
         m_inf     <= 1'b1;
         op_req    <= 1'b0;
         op_dbl    <= 1'b0;
         op_ax     <= '0;
         op_ay     <= '0;
         op_a_inf  <= 1'b0;
         op_bx     <= '0;
         op_by     <= '0;
         op_b_inf  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  k_reg     <= secret_key;
                  c1x_reg   <= c1x;
                  c1y_reg   <= c1y;
                  c2x_reg   <= c2x;
                  c2y_reg   <= c2y;
                  r_inf_reg <= 1'b1;
                  idx_reg   <= IW'(WIDTH - 1);
                  busy      <= 1'b1;
                  state_reg <= S_DBL;
               end
            end
            S_DBL: begin
               if (r_inf_reg) begin
                  state_reg <= S_ADD;
               end else begin
                  op_req    <= 1'b1;
                  op_dbl    <= 1'b1;
                  op_ax     <= rx_reg;
                  op_ay     <= ry_reg;
                  op_a_inf  <= 1'b0;
                  state_reg <= S_DBL_WAIT;
               end
            end
            S_DBL_WAIT: begin
               if (op_done) begin
                  op_req    <= 1'b0;
                  rx_reg    <= op_rx;
                  ry_reg    <= op_ry;
                  r_inf_reg <= op_r_inf;
                  state_reg <= S_ADD;
               end
            end
            S_ADD: begin
               if (!k_reg[idx_reg]) begin
                  state_reg <= S_NEXT;
               end else if (r_inf_reg) begin
                  // infinity + C1 needs no point unit round trip
                  rx_reg    <= c1x_reg;
                  ry_reg    <= c1y_reg;
                  r_inf_reg <= 1'b0;
                  state_reg <= S_NEXT;
               end else begin
                  op_req    <= 1'b1;
                  op_dbl    <= 1'b0;
                  op_ax     <= rx_reg;
                  op_ay     <= ry_reg;
                  op_a_inf  <= 1'b0;
                  op_bx     <= c1x_reg;
                  op_by     <= c1y_reg;
                  op_b_inf  <= 1'b0;
                  state_reg <= S_ADD_WAIT;
               end
            end
            S_ADD_WAIT: begin
               if (op_done) begin
                  op_req    <= 1'b0;
                  rx_reg    <= op_rx;
                  ry_reg    <= op_ry;
                  r_inf_reg <= op_r_inf;
                  state_reg <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (idx_reg == '0) begin
                  state_reg <= S_SUB;
               end else begin
                  idx_reg   <= idx_reg - 1'b1;
                  state_reg <= S_DBL;
               end
            end
            S_SUB: begin
               if (r_inf_reg) begin
                  mx        <= c2x_reg;
                  my        <= c2y_reg;
                  m_inf     <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  op_req    <= 1'b1;
                  op_dbl    <= 1'b0;
                  op_ax     <= c2x_reg;
                  op_ay     <= c2y_reg;
                  op_a_inf  <= 1'b0;
                  op_bx     <= rx_reg;
                  op_by     <= neg_y;
                  op_b_inf  <= 1'b0;
                  state_reg <= S_SUB_WAIT;
               end
            end
            S_SUB_WAIT: begin
               if (op_done) begin
                  op_req    <= 1'b0;
                  mx        <= op_rx;
                  my        <= op_ry;
                  m_inf     <= op_r_inf;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ec_decrypt_seq.sv
// Bench for ec_decrypt_seq on y^2 = x^3 + x + 1 mod 23 with a behavioural point unit,
// a repeated-addition reference model and a scoreboard checked on every done pulse.
module tb_ec_decrypt_seq;

   localparam int W = 8;
   localparam int P = 23;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] secret_key = '0, c1x = '0, c1y = '0, c2x = '0, c2y = '0;
   logic         busy, done, m_inf;
   logic [W-1:0] mx, my;
   logic         op_req, op_dbl, op_a_inf, op_b_inf;
   logic [W-1:0] op_ax, op_ay, op_bx, op_by;
   logic         op_ack = 1'b0;
   logic [W-1:0] op_rx = '0, op_ry = '0;
   logic         op_r_inf = 1'b0;

   always #5 clk = ~clk;

   ec_decrypt_seq #(.WIDTH(W), .PRIME(P)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .secret_key(secret_key),
      .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
      .busy(busy), .done(done), .mx(mx), .my(my), .m_inf(m_inf),
      .op_req(op_req), .op_dbl(op_dbl),
      .op_ax(op_ax), .op_ay(op_ay), .op_a_inf(op_a_inf),
      .op_bx(op_bx), .op_by(op_by), .op_b_inf(op_b_inf),
      .op_ack(op_ack), .op_rx(op_rx), .op_ry(op_ry), .op_r_inf(op_r_inf)
   );

   typedef struct packed {bit inf; int x; int y;} pt_t;
   typedef struct packed {bit dbl; int ax; int ay; int bx; int by;} req_t;

   pt_t  sb_q[$];
   req_t req_log[$];
   pt_t  curve_pts[$];
   int   checks = 0;
   int   fails = 0;
   int   ack_delay = 3;
   int   stray_req = 0;
   int   stray_done = 0;
   int   txn = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- group arithmetic (affine, a=1, b=1) ----------------
   function automatic int md(int v);
      return ((v % P) + P) % P;
   endfunction

   function automatic int inv(int v);
      int r = 1;
      for (int e = 0; e < P - 2; e++) r = (r * v) % P;
      return r;
   endfunction

   function automatic pt_t padd(pt_t a, pt_t b);
      pt_t r;
      int  l;
      r = '{1'b1, 0, 0};
      if (a.inf) return b;
      if (b.inf) return a;
      if (a.x == b.x) begin
         if (md(a.y + b.y) == 0) return r;
         l = md((3 * a.x * a.x + 1) * inv(md(2 * a.y)));
      end else begin
         l = md(md(b.y - a.y) * inv(md(b.x - a.x)));
      end
      r.inf = 1'b0;
      r.x   = md(l * l - a.x - b.x);
      r.y   = md(l * (a.x - r.x) - a.y);
      return r;
   endfunction

   // M = C2 + (-(C1 + C1 + ... k times))
   function automatic pt_t ref_decrypt(int k, pt_t c1, pt_t c2);
      pt_t s;
      s = '{1'b1, 0, 0};
      for (int j = 0; j < k; j++) s = padd(s, c1);
      if (!s.inf) s.y = md(-s.y);
      return padd(c2, s);
   endfunction

   // ---------------- point unit model ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (stray_req != stray_done) begin
            op_rx = 8'h55; op_ry = 8'h66; op_r_inf = 1'b0; op_ack = 1'b1;
            @(negedge clk);
            op_ack = 1'b0;
            stray_done++;
         end else if (op_req && rst_n) begin
            req_t         r;
            pt_t          a, b, res;
            bit           aborted;
            logic [35:0]  snap;
            r = '{op_dbl, int'(op_ax), int'(op_ay), int'(op_bx), int'(op_by)};
            req_log.push_back(r);
            a = '{op_a_inf, int'(op_ax), int'(op_ay)};
            b = '{op_b_inf, int'(op_bx), int'(op_by)};
            res = op_dbl ? padd(a, a) : padd(a, b);
            snap = {op_req, op_dbl, op_ax, op_ay, op_a_inf, op_bx, op_by, op_b_inf};
            aborted = 1'b0;
            for (int d = 1; d < ack_delay; d++) begin
               @(negedge clk);
               if (!rst_n) aborted = 1'b1;
               if (!aborted)
                  chk("op_stable", {op_req, op_dbl, op_ax, op_ay, op_a_inf, op_bx, op_by, op_b_inf}, snap);
            end
            op_rx = W'(res.x); op_ry = W'(res.y); op_r_inf = res.inf; op_ack = 1'b1;
            @(negedge clk);
            op_ack = 1'b0;
            if (!aborted) chk("op_req_drop", op_req, 1'b0);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("done_unexpected", done, 1'b0);
         end else begin
            pt_t e;
            e = sb_q.pop_front();
            txn++;
            $display("txn %0d: m=(%0d,%0d) inf=%0b exp=(%0d,%0d) inf=%0b", txn, mx, my, m_inf, e.x, e.y, e.inf);
            chk("m_inf", m_inf, e.inf);
            if (!e.inf) begin
               chk("mx", mx, e.x);
               chk("my", my, e.y);
            end
            chk("busy_at_done", busy, 1'b0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_op(int k, pt_t c1, pt_t c2, int dly);
      ack_delay = dly;
      @(negedge clk);
      secret_key = W'(k); c1x = W'(c1.x); c1y = W'(c1.y); c2x = W'(c2.x); c2y = W'(c2.y);
      start = 1'b1;
      sb_q.push_back(ref_decrypt(k, c1, c2));
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done(int budget, output int n);
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", done, 1'b1);
   endtask

   function automatic pt_t rnd_pt();
      return curve_pts[$urandom_range(0, curve_pts.size() - 1)];
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pt_t c1, c2, pa, pb;
      int  n;
      logic [W-1:0] sx, sy;
      logic         sinf;

      for (int x = 0; x < P; x++)
         for (int y = 0; y < P; y++)
            if (md(y * y) == md(x * x * x + x + 1)) curve_pts.push_back('{1'b0, x, y});

      c1 = '{1'b0, 3, 10};
      c2 = '{1'b0, 7, 12};

      // reset state
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_op_req", op_req, 1'b0);
      chk("rst_m_inf", m_inf, 1'b1);
      chk("rst_mxy", {mx, my}, 16'd0);
      chk("rst_op_data", {op_dbl, op_ax, op_ay, op_a_inf, op_bx, op_by, op_b_inf}, 35'd0);
      rst_n = 1'b1;

      // k=1: single SUB request with B=(3,13)
      req_log.delete();
      run_op(1, c1, c2, 3);
      wait_done(600, n);
      chk("t2_req_cnt", req_log.size(), 1);
      if (req_log.size() == 1) begin
         chk("t2_dbl", req_log[0].dbl, 1'b0);
         chk("t2_a", {req_log[0].ax[7:0], req_log[0].ay[7:0]}, {8'd7, 8'd12});
         chk("t2_b", {req_log[0].bx[7:0], req_log[0].by[7:0]}, {8'd3, 8'd13});
      end
      chk("t2_m", {m_inf, mx, my}, {1'b0, 8'd3, 8'd10});

      // k=2: DBL then SUB, result at infinity
      req_log.delete();
      run_op(2, c1, c2, 3);
      wait_done(600, n);
      chk("t3_req_cnt", req_log.size(), 2);
      if (req_log.size() == 2) begin
         chk("t3_dbl", {req_log[0].dbl, req_log[1].dbl}, 2'b10);
         chk("t3_dbl_a", {req_log[0].ax[7:0], req_log[0].ay[7:0]}, {8'd3, 8'd10});
         chk("t3_sub_b", {req_log[1].bx[7:0], req_log[1].by[7:0]}, {8'd7, 8'd11});
      end
      chk("t3_m_inf", m_inf, 1'b1);

      // k=0: no requests, exact latency
      req_log.delete();
      run_op(0, c1, c2, 3);
      wait_done(600, n);
      chk("t4_req_cnt", req_log.size(), 0);
      chk("t4_latency", n, 3 * W + 1);
      chk("t4_m", {m_inf, mx, my}, {1'b0, 8'd7, 8'd12});

      // k=3 with slow ack: DBL, ADD, SUB
      req_log.delete();
      run_op(3, c1, c2, 5);
      wait_done(900, n);
      chk("t5_req_cnt", req_log.size(), 3);
      if (req_log.size() == 3) begin
         chk("t5_order", {req_log[0].dbl, req_log[1].dbl, req_log[2].dbl}, 3'b100);
         chk("t5_add_ab", {req_log[1].ax[7:0], req_log[1].ay[7:0], req_log[1].bx[7:0], req_log[1].by[7:0]},
             {8'd7, 8'd12, 8'd3, 8'd10});
      end
      // stray ack while idle
      @(negedge clk);
      sx = mx; sy = my; sinf = m_inf;
      stray_req++;
      repeat (4) @(negedge clk);
      chk("stray_m", {m_inf, mx, my}, {sinf, sx, sy});
      chk("stray_busy", {busy, op_req}, 2'b00);

      // start while busy and in DONE is ignored
      pa = rnd_pt(); pb = rnd_pt();
      run_op(5, pa, pb, 2);
      repeat (4) @(negedge clk);
      secret_key = 8'hAA; c1x = 8'd0; c1y = 8'd1; c2x = 8'd0; c2y = 8'd22;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(600, n);
      secret_key = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t6_idle_busy", busy, 1'b0);
      end

      // reset in ADD_WAIT aborts; late ack ignored
      run_op(255, c1, c2, 3);
      n = 0;
      while (!(op_req && !op_dbl) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("t1_reach_add_wait", op_req && !op_dbl, 1'b1);
      #2 rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("t1_busy", busy, 1'b0);
      chk("t1_op_req", op_req, 1'b0);
      chk("t1_m_inf", m_inf, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t1_late_ack", {busy, m_inf}, 2'b01);
      run_op(7, c1, c2, 2);
      wait_done(600, n);

      // randomized
      for (int t = 0; t < 20; t++) begin
         pa = rnd_pt(); pb = rnd_pt();
         run_op($urandom_range(0, 255), pa, pb, $urandom_range(1, 4));
         wait_done(800, n);
      end

      repeat (3) @(negedge clk);
      chk("pending_results", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
